// File: rtl/sync_fifo_buf_if.sv
// Handshake bundle between a producer/consumer pair and sync_fifo_buf.
// Optional max_level signal is present when SYNC_FIFO_BUF_WATERMARK_EN is defined.
interface sync_fifo_buf_if #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 8
);
    logic                winc;
    logic [DATASIZE-1:0] wdata;
    logic                rinc;
    logic [DATASIZE-1:0] rdata;
    logic                rvalid;
    logic                wfull;
    logic                rempty;
    logic                walmost_full;
    logic                ralmost_empty;
    logic [ADDRSIZE:0]   count;
    logic                clr_err;
    logic                overflow;
    logic                underflow;
`ifdef SYNC_FIFO_BUF_WATERMARK_EN
    logic [ADDRSIZE:0]   max_level;
`endif

    modport master (
        output winc, wdata, rinc, clr_err,
        input  rdata, rvalid, wfull, rempty,
        input  walmost_full, ralmost_empty, count,
`ifdef SYNC_FIFO_BUF_WATERMARK_EN
        input  max_level,
`endif
        input  overflow, underflow
    );

    modport slave (
        input  winc, wdata, rinc, clr_err,
        output rdata, rvalid, wfull, rempty,
        output walmost_full, ralmost_empty, count,
`ifdef SYNC_FIFO_BUF_WATERMARK_EN
        output max_level,
`endif
        output overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_buf.sv
// Single-clock FIFO, 2**ADDRSIZE entries, registered read data and sticky errors.
// Define SYNC_FIFO_BUF_WATERMARK_EN to add the max_level high-water mark.
module sync_fifo_buf #(
    parameter int DATASIZE      = 8,
    parameter int ADDRSIZE      = 8,
    parameter int AFULL_THRESH  = (1 << ADDRSIZE) - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input logic            wclk,
    input logic            wrst_n,
    sync_fifo_buf_if.slave bus
);
    localparam int DEPTH = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] C_DEPTH  = (ADDRSIZE+1)'(DEPTH);
    localparam logic [ADDRSIZE:0] C_AFULL  = (ADDRSIZE+1)'(AFULL_THRESH);
    localparam logic [ADDRSIZE:0] C_AEMPTY = (ADDRSIZE+1)'(AEMPTY_THRESH);
    localparam logic [ADDRSIZE:0] C_CNT1   = (ADDRSIZE+1)'(1);
    localparam logic [ADDRSIZE-1:0] C_PTR1 = ADDRSIZE'(1);

    logic [DATASIZE-1:0] r_mem [DEPTH];
    logic [ADDRSIZE-1:0] r_wptr;
    logic [ADDRSIZE-1:0] r_rptr;
    logic [ADDRSIZE:0]   r_count;
    logic [DATASIZE-1:0] r_rdata;
    logic                r_rvalid;
    logic                r_overflow;
    logic                r_underflow;

    logic                w_full;
    logic                w_empty;
    logic                w_rd_acc;
    logic                w_wr_acc;
    logic                w_wr_rej;
    logic                w_rd_rej;
    logic [ADDRSIZE:0]   w_count_nxt;

    assign w_full  = (r_count == C_DEPTH);
    assign w_empty = (r_count == '0);

    // A full FIFO still takes a write when a read frees the slot this cycle
    assign w_rd_acc = bus.rinc && !w_empty;
    assign w_wr_acc = bus.winc && (!w_full || w_rd_acc);
    assign w_wr_rej = bus.winc && !w_wr_acc;
    assign w_rd_rej = bus.rinc && w_empty;

    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + C_CNT1;
            2'b01:   w_count_nxt = r_count - C_CNT1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (wrst_n && w_wr_acc) begin
            r_mem[r_wptr] <= bus.wdata;
        end
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_count  <= w_count_nxt;
            r_rvalid <= w_rd_acc;
            if (w_wr_acc) begin
                r_wptr <= r_wptr + C_PTR1;
            end
            if (w_rd_acc) begin
                r_rdata <= r_mem[r_rptr];
                r_rptr  <= r_rptr + C_PTR1;
            end
        end
    end

    // Sticky errors: a fresh error outranks a clear in the same cycle
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_wr_rej || (r_overflow && !bus.clr_err);
            r_underflow <= w_rd_rej || (r_underflow && !bus.clr_err);
        end
    end

`ifdef SYNC_FIFO_BUF_WATERMARK_EN
    logic [ADDRSIZE:0] r_max_level;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_max_level <= '0;
        end else if (bus.clr_err) begin
            r_max_level <= r_count;
        end else if (r_count > r_max_level) begin
            r_max_level <= r_count;
        end
    end

    assign bus.max_level = r_max_level;
`endif

    assign bus.rdata         = r_rdata;
    assign bus.rvalid        = r_rvalid;
    assign bus.count         = r_count;
    assign bus.wfull         = w_full;
    assign bus.rempty        = w_empty;
    assign bus.walmost_full  = (r_count >= C_AFULL);
    assign bus.ralmost_empty = (r_count <= C_AEMPTY);
    assign bus.overflow      = r_overflow;
    assign bus.underflow     = r_underflow;
endmodule

// File: tb/tb_sync_fifo_buf.sv
// Randomized and directed bench for sync_fifo_buf against a queue reference.
// Watermark checks are compiled in with SYNC_FIFO_BUF_WATERMARK_EN.
module tb_sync_fifo_buf;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rdata;
    logic          m_rvalid;
    logic          m_ovf;
    logic          m_udf;
    int            m_ml;

    always #5 clk = ~clk;

    sync_fifo_buf_if #(.DATASIZE(DW), .ADDRSIZE(AW)) bus ();

    sync_fifo_buf #(.DATASIZE(DW), .ADDRSIZE(AW)) dut (
        .wclk  (clk),
        .wrst_n(rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rdata  = '0;
        m_rvalid = 1'b0;
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        m_ml     = 0;
    endtask

    task automatic model_edge(input logic w, input logic [DW-1:0] d,
                              input logic r, input logic c);
        int  n;
        logic rd;
        logic wr;
        n  = q.size();
        rd = r && (n != 0);
        wr = w && ((n != DEPTH) || rd);
        m_rvalid = rd;
        if (rd) m_rdata = q.pop_front();
        if (wr) q.push_back(d);
        m_ovf = (w && !wr) || (m_ovf && !c);
        m_udf = (r && n == 0) || (m_udf && !c);
        if (c) m_ml = n;
        else if (n > m_ml) m_ml = n;
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("count", 32'(bus.count), n);
        chk("rempty", 32'(bus.rempty), 32'(n == 0));
        chk("wfull", 32'(bus.wfull), 32'(n == DEPTH));
        chk("walmost_full", 32'(bus.walmost_full), 32'(n >= DEPTH - 4));
        chk("ralmost_empty", 32'(bus.ralmost_empty), 32'(n <= 4));
        chk("rvalid", 32'(bus.rvalid), 32'(m_rvalid));
        chk("rdata", 32'(bus.rdata), 32'(m_rdata));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("underflow", 32'(bus.underflow), 32'(m_udf));
`ifdef SYNC_FIFO_BUF_WATERMARK_EN
        chk("max_level", 32'(bus.max_level), m_ml);
`endif
    endtask

    task automatic step(input logic w, input logic [DW-1:0] d,
                        input logic r, input logic c);
        bus.winc    = w;
        bus.wdata   = d;
        bus.rinc    = r;
        bus.clr_err = c;
        @(posedge clk);
        model_edge(w, d, r, c);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        rst_n = 1'b1;
        check_all();
    endtask

    initial begin
        int pw[8] = '{90, 10, 70, 30, 95, 50, 5, 60};
        bus.winc    = 1'b0;
        bus.wdata   = '0;
        bus.rinc    = 1'b0;
        bus.clr_err = 1'b0;
        model_reset();

        // 1: single write and read
        do_reset();
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // 2: fill, overflow, drain in order
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // 3: full with simultaneous traffic across pointer wrap
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i * 3), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 8'(200 + i), 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // 4: empty with simultaneous traffic, then clear
        do_reset();
        step(1'b1, 8'h3C, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // 5: reset mid-operation
        do_reset();
        for (int i = 0; i < 101; i++) step(1'b1, 8'(i + 1), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        do_reset();
        step(1'b0, 8'h00, 1'b1, 1'b0);

`ifdef SYNC_FIFO_BUF_WATERMARK_EN
        // 6: high-water mark
        do_reset();
        for (int i = 0; i < 40; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 35; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
`endif

        // random traffic with shifting write/read bias
        do_reset();
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 600; k++) begin
                logic w;
                logic r;
                logic c;
                w = ($urandom_range(99) < pw[b]);
                r = ($urandom_range(99) < (100 - pw[b]));
                c = ($urandom_range(63) == 0);
                if ($urandom_range(1499) == 0) do_reset();
                else step(w, 8'($urandom), r, c);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
